// File: rtl/td4x_pkg.sv
// ----------------------------------------------------------------------------
// td4x_pkg
// Shared definitions for the td4x accumulator core: opcode constants, the
// core state encoding, ALU source-select encodings and the source-select
// helper used by the decoder.
// No ports (package).
// ----------------------------------------------------------------------------
package td4x_pkg;

  // Opcodes: instruction = {op[3:0], imm[DATA_W-1:0]}
  localparam logic [3:0] OP_ADD_A  = 4'b0000;  // A <= A + imm
  localparam logic [3:0] OP_MOV_AB = 4'b0001;  // A <= B + imm
  localparam logic [3:0] OP_IN_A   = 4'b0010;  // A <= sw + imm
  localparam logic [3:0] OP_MOV_A  = 4'b0011;  // A <= imm
  localparam logic [3:0] OP_MOV_BA = 4'b0100;  // B <= A + imm
  localparam logic [3:0] OP_ADD_B  = 4'b0101;  // B <= B + imm
  localparam logic [3:0] OP_IN_B   = 4'b0110;  // B <= sw + imm
  localparam logic [3:0] OP_MOV_B  = 4'b0111;  // B <= imm
  localparam logic [3:0] OP_OUT_BI = 4'b1000;  // LED <= B + imm
  localparam logic [3:0] OP_OUT_B  = 4'b1001;  // LED <= B (+imm)
  localparam logic [3:0] OP_OUT_SW = 4'b1010;  // LED destination, source from select formula
  localparam logic [3:0] OP_OUT_I  = 4'b1011;  // LED <= imm
  localparam logic [3:0] OP_JNC_B  = 4'b1100;  // if !C: ip <= B + imm
  localparam logic [3:0] OP_HLT    = 4'b1101;  // stop until reset
  localparam logic [3:0] OP_JNC    = 4'b1110;  // if !C: ip <= imm
  localparam logic [3:0] OP_JMP    = 4'b1111;  // ip <= imm

  // ALU source select encodings
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_SW   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  // Source select is a pure function of the opcode bits: {op[1], op[0]|op[3]}.
  // The op[3] term routes every LED/jump opcode away from A, so 1010 and
  // 1011 both resolve to the zero source.
  function automatic logic [1:0] src_sel(input logic [3:0] op);
    return {op[1], (op[0] | op[3])};
  endfunction

endpackage

// File: rtl/td4x_if.sv
// ----------------------------------------------------------------------------
// td4x_if
// Instruction-fetch handshake between the core (master) and a program memory
// (slave).
//   req   master->slave  fetch request, held until ack
//   addr  master->slave  fetch address, stable while req=1
//   ack   slave->master  data is valid this cycle
//   data  slave->master  instruction word {op[3:0], imm[DATA_W-1:0]}
// ----------------------------------------------------------------------------
interface td4x_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  localparam int INSTR_W = 4 + DATA_W;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/td4x_decode.sv
// ----------------------------------------------------------------------------
// td4x_decode
// Combinational opcode decoder.
//   i_op            opcode
//   o_sel           ALU source select (SEL_A/SEL_B/SEL_SW/SEL_ZERO)
//   o_dest_a/b/led  destination register strobes
//   o_jump_cond     jump when C=0
//   o_jump_always   unconditional jump
//   o_hlt           halt instruction
// ----------------------------------------------------------------------------
module td4x_decode
  import td4x_pkg::*;
(
  input  logic [3:0] i_op,
  output logic [1:0] o_sel,
  output logic       o_dest_a,
  output logic       o_dest_b,
  output logic       o_dest_led,
  output logic       o_jump_cond,
  output logic       o_jump_always,
  output logic       o_hlt
);

  // Destination / control decode; every strobe defaults low
  always_comb begin
    o_sel         = src_sel(i_op);
    o_dest_a      = 1'b0;
    o_dest_b      = 1'b0;
    o_dest_led    = 1'b0;
    o_jump_cond   = 1'b0;
    o_jump_always = 1'b0;
    o_hlt         = 1'b0;
    case (i_op)
      OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A:    o_dest_a      = 1'b1;
      OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_B:    o_dest_b      = 1'b1;
      OP_OUT_BI, OP_OUT_B, OP_OUT_SW, OP_OUT_I:  o_dest_led    = 1'b1;
      OP_JNC_B, OP_JNC:                          o_jump_cond   = 1'b1;
      OP_JMP:                                    o_jump_always = 1'b1;
      OP_HLT:                                    o_hlt         = 1'b1;
      default:                                   o_hlt         = 1'b0;
    endcase
  end

endmodule

// File: rtl/td4x_core.sv
// ----------------------------------------------------------------------------
// td4x_core
// Parametrised TD4-style accumulator core with req/ack instruction fetch.
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_run        1 = fetch/execute continuously, 0 = stop at next boundary
//   i_sw         input switches (already synchronised by the board top)
//   o_led        output latch
//   o_led_valid  one-cycle pulse whenever o_led is written
//   o_halted     core has executed HLT
//   imem         fetch handshake (master side)
// ----------------------------------------------------------------------------
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_sw,
  output logic [DATA_W-1:0] o_led,
  output logic              o_led_valid,
  output logic              o_halted,
  td4x_if.master            imem
);

  localparam int INSTR_W = 4 + DATA_W;

  if ((DATA_W < 4) || (DATA_W > 16) || (ADDR_W < 2) || (ADDR_W > DATA_W)) begin : g_bad_param
    $error("td4x_core: DATA_W must be 4..16 and ADDR_W must be 2..DATA_W");
  end

  state_e              r_state;
  state_e              w_next_state;
  logic                r_req;
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_led;
  logic [ADDR_W-1:0]   r_ip;
  logic                r_c;
  logic                r_led_valid;
  logic                r_halted;

  logic [3:0]          w_op;
  logic [DATA_W-1:0]   w_imm;
  logic [1:0]          w_sel;
  logic                w_dest_a;
  logic                w_dest_b;
  logic                w_dest_led;
  logic                w_jump_cond;
  logic                w_jump_always;
  logic                w_hlt;
  logic [DATA_W-1:0]   w_src;
  logic [DATA_W:0]     w_sum;
  logic                w_take_jump;
  logic [ADDR_W-1:0]   w_next_ip;

  assign w_op  = r_instr[INSTR_W-1 -: 4];
  assign w_imm = r_instr[DATA_W-1:0];

  td4x_decode u_decode (
    .i_op          (w_op),
    .o_sel         (w_sel),
    .o_dest_a      (w_dest_a),
    .o_dest_b      (w_dest_b),
    .o_dest_led    (w_dest_led),
    .o_jump_cond   (w_jump_cond),
    .o_jump_always (w_jump_always),
    .o_hlt         (w_hlt)
  );

  // ALU source mux, DATA_W+1 bit add and next-ip selection
  always_comb begin
    w_src = {DATA_W{1'b0}};
    case (w_sel)
      SEL_A:    w_src = r_a;
      SEL_B:    w_src = r_b;
      SEL_SW:   w_src = i_sw;
      default:  w_src = {DATA_W{1'b0}};
    endcase
    w_sum = {1'b0, w_src} + {1'b0, w_imm};
    // jnc looks at the carry left by the previous instruction
    w_take_jump = w_jump_always | (w_jump_cond & ~r_c);
    if (w_take_jump) begin
      w_next_ip = w_sum[ADDR_W-1:0];
    end else begin
      w_next_ip = r_ip + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_run) w_next_state = ST_FETCH;
        else       w_next_state = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem.ack) w_next_state = ST_EXEC;
        else          w_next_state = ST_FETCH;
      end
      ST_EXEC: begin
        if (w_hlt)      w_next_state = ST_HALT;
        else if (i_run) w_next_state = ST_FETCH;
        else            w_next_state = ST_IDLE;
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register; req is registered from the next state so it drops on the ack edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_req   <= (w_next_state == ST_FETCH);
    end
  end

  // Instruction latch; data is only looked at while fetching
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= {INSTR_W{1'b0}};
    end else if ((r_state == ST_FETCH) && imem.ack) begin
      r_instr <= imem.data;
    end
  end

  // Architectural state commit in EXEC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a   <= {DATA_W{1'b0}};
      r_b   <= {DATA_W{1'b0}};
      r_led <= {DATA_W{1'b0}};
      r_ip  <= {ADDR_W{1'b0}};
      r_c   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_ip <= w_next_ip;
      if (!w_hlt)     r_c   <= w_sum[DATA_W];
      if (w_dest_a)   r_a   <= w_sum[DATA_W-1:0];
      if (w_dest_b)   r_b   <= w_sum[DATA_W-1:0];
      if (w_dest_led) r_led <= w_sum[DATA_W-1:0];
    end
  end

  // LED write strobe and sticky halt flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_led_valid <= (r_state == ST_EXEC) && w_dest_led;
      if ((r_state == ST_EXEC) && w_hlt) r_halted <= 1'b1;
    end
  end

  assign imem.req    = r_req;
  assign imem.addr   = r_ip;
  assign o_led       = r_led;
  assign o_led_valid = r_led_valid;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_td4x_core.sv
// ----------------------------------------------------------------------------
// tb_td4x_core
// Directed bench for td4x_core (DATA_W=4/ADDR_W=4 and DATA_W=8/ADDR_W=6)
// plus an exhaustive sweep of td4x_decode. A behavioural program memory with
// programmable ack latency sits on each fetch interface.
// ----------------------------------------------------------------------------
module tb_td4x_core;

  logic       clk = 1'b0;
  logic       rst_n4 = 1'b0;
  logic       rst_n8 = 1'b0;
  logic       run4 = 1'b0;
  logic       run8 = 1'b0;
  logic [3:0] sw4 = 4'h0;
  logic [7:0] sw8 = 8'h00;
  logic [3:0] led4;
  logic [7:0] led8;
  logic       lv4, lv8, h4, h8;

  logic [7:0]  mem4 [16];
  logic [11:0] mem8 [64];
  int lat4 = 100;
  int lat8 = 0;
  int wait4 = 0;
  int wait8 = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  td4x_if #(.DATA_W(4), .ADDR_W(4)) bus4 ();
  td4x_if #(.DATA_W(8), .ADDR_W(6)) bus8 ();

  // Program memory models: ack after lat cycles of held request
  assign bus4.ack  = bus4.req && (wait4 == lat4);
  assign bus4.data = mem4[bus4.addr];
  assign bus8.ack  = bus8.req && (wait8 == lat8);
  assign bus8.data = mem8[bus8.addr];

  always @(posedge clk) begin
    if (!bus4.req || bus4.ack) wait4 <= 0; else wait4 <= wait4 + 1;
    if (!bus8.req || bus8.ack) wait8 <= 0; else wait8 <= wait8 + 1;
  end

  td4x_core #(.DATA_W(4), .ADDR_W(4)) u_core4 (
    .i_clk(clk), .i_rst_n(rst_n4), .i_run(run4), .i_sw(sw4),
    .o_led(led4), .o_led_valid(lv4), .o_halted(h4), .imem(bus4)
  );

  td4x_core #(.DATA_W(8), .ADDR_W(6)) u_core8 (
    .i_clk(clk), .i_rst_n(rst_n8), .i_run(run8), .i_sw(sw8),
    .o_led(led8), .o_led_valid(lv8), .o_halted(h8), .imem(bus8)
  );

  logic [3:0] dec_op = 4'h0;
  logic [1:0] d_sel;
  logic       d_a, d_b, d_led, d_jc, d_ja, d_hlt;

  td4x_decode u_dec (
    .i_op(dec_op), .o_sel(d_sel), .o_dest_a(d_a), .o_dest_b(d_b),
    .o_dest_led(d_led), .o_jump_cond(d_jc), .o_jump_always(d_ja), .o_hlt(d_hlt)
  );

  // Hand-derived decode table: {sel[1:0], dest_a, dest_b, dest_led, jc, ja, hlt}
  localparam logic [7:0] DEC_EXP [16] = '{
    8'h20, 8'h60, 8'hA0, 8'hE0,
    8'h10, 8'h50, 8'h90, 8'hD0,
    8'h48, 8'h48, 8'hC8, 8'hC8,
    8'h44, 8'h41, 8'hC4, 8'hC2
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
    for (int i = 0; i < 64; i++) mem8[i] = 12'h000;

    // Decoder sweep
    for (int i = 0; i < 16; i++) begin
      dec_op = i[3:0];
      #1;
      check($sformatf("decode_op%0d", i), {24'h0, d_sel, d_a, d_b, d_led, d_jc, d_ja, d_hlt}, {24'h0, DEC_EXP[i]});
    end

    // Reset state
    step(2);
    check("rst_led", led4, 4'h0);
    check("rst_ip", u_core4.r_ip, 4'h0);
    check("rst_req", bus4.req, 1'b0);
    check("rst_halted", h4, 1'b0);
    check("rst_led_valid", lv4, 1'b0);

    // First request at addr 0, held with no ack
    rst_n4 = 1'b1;
    run4   = 1'b1;
    step(1);
    check("req_first", bus4.req, 1'b1);
    check("addr_first", bus4.addr, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("req_hold%0d", i), bus4.req, 1'b1);
      check($sformatf("addr_hold%0d", i), bus4.addr, 4'h0);
    end
    rst_n4 = 1'b0;
    #1;
    check("req_async_drop4", bus4.req, 1'b0);

    // Program with zero ack latency
    mem4[0]  = 8'h37;  // A=7
    mem4[1]  = 8'h09;  // A=0, C=1
    mem4[2]  = 8'hE0;  // jnc 0, not taken
    mem4[3]  = 8'hB5;  // out 5
    mem4[4]  = 8'hB5;  // out 5 again
    mem4[5]  = 8'hFD;  // jmp D
    mem4[13] = 8'h3F;  // A=F
    mem4[14] = 8'h01;  // A=0, C=1
    mem4[15] = 8'hF5;  // jmp 5
    lat4 = 0;
    step(1);
    rst_n4 = 1'b1;

    step(3);
    check("i0_a", u_core4.r_a, 4'h7);
    check("i0_c", u_core4.r_c, 1'b0);
    check("i0_ip", u_core4.r_ip, 4'h1);
    step(2);
    check("i1_a", u_core4.r_a, 4'h0);
    check("i1_c", u_core4.r_c, 1'b1);
    check("i1_ip", u_core4.r_ip, 4'h2);
    step(2);
    check("jnc_not_taken_ip", u_core4.r_ip, 4'h3);
    check("jnc_own_carry", u_core4.r_c, 1'b0);
    step(2);
    check("out_led", led4, 4'h5);
    check("out_valid", lv4, 1'b1);
    step(1);
    check("out_valid_drop", lv4, 1'b0);
    step(1);
    check("out_repeat_valid", lv4, 1'b1);
    check("out_repeat_led", led4, 4'h5);
    step(1);
    check("out_repeat_drop", lv4, 1'b0);
    step(1);
    check("jmp_d_ip", u_core4.r_ip, 4'hD);
    step(2);
    check("movf_a", u_core4.r_a, 4'hF);
    step(2);
    check("at_f_ip", u_core4.r_ip, 4'hF);
    check("at_f_c", u_core4.r_c, 1'b1);
    step(2);
    check("jmp5_ip", u_core4.r_ip, 4'h5);
    check("jmp5_c", u_core4.r_c, 1'b0);

    // Next pass: plain add at ip=F wraps to 0, where a HLT now waits
    mem4[15] = 8'h00;
    mem4[0]  = 8'hD0;
    step(6);
    check("pass2_ip_f", u_core4.r_ip, 4'hF);
    step(2);
    check("wrap_ip", u_core4.r_ip, 4'h0);
    check("wrap_c", u_core4.r_c, 1'b0);
    check("pre_halt", h4, 1'b0);
    step(2);
    check("halted", h4, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check($sformatf("halt_noreq%0d", i), bus4.req, 1'b0);
    end
    rst_n4 = 1'b0;
    #1;
    check("halt_cleared", h4, 1'b0);
    check("halt_rst_ip", u_core4.r_ip, 4'h0);

    // Wide core: DATA_W=8, ADDR_W=6
    mem8[0]  = 12'h3FF;  // A=FF
    mem8[1]  = 12'h001;  // A=00, C=1
    mem8[2]  = 12'hE05;  // jnc 5, not taken
    mem8[3]  = 12'h712;  // B=12
    mem8[4]  = 12'hC05;  // jnc B+5 -> 0x17, taken
    mem8[23] = 12'h101;  // A=B+1=13
    mem8[24] = 12'h900;  // out B -> 12
    mem8[25] = 12'h6F0;  // B=sw+F0 = 1A, C=1
    mem8[26] = 12'hD00;  // halt
    sw8 = 8'h2A;
    lat8 = 0;
    step(1);
    rst_n8 = 1'b1;
    run8   = 1'b1;
    step(3);
    check("w_i0_a", u_core8.r_a, 8'hFF);
    check("w_i0_c", u_core8.r_c, 1'b0);
    step(2);
    check("w_i1_a", u_core8.r_a, 8'h00);
    check("w_i1_c", u_core8.r_c, 1'b1);
    check("w_i1_ip", u_core8.r_ip, 6'h02);
    step(2);
    check("w_jnc_nt_ip", u_core8.r_ip, 6'h03);
    step(2);
    check("w_movb", u_core8.r_b, 8'h12);
    step(2);
    check("w_jnc_t_ip", u_core8.r_ip, 6'h17);
    step(2);
    check("w_mov_ab", u_core8.r_a, 8'h13);
    step(2);
    check("w_out_led", led8, 8'h12);
    check("w_out_valid", lv8, 1'b1);
    step(2);
    check("w_in_b", u_core8.r_b, 8'h1A);
    check("w_in_c", u_core8.r_c, 1'b1);
    step(2);
    check("w_halted", h8, 1'b1);

    // Reset during an ack delay of 3
    rst_n8 = 1'b0;
    #1;
    check("w_rst_halted", h8, 1'b0);
    mem8[0] = 12'h305;  // A=05
    lat8 = 3;
    step(1);
    rst_n8 = 1'b1;
    step(2);
    check("w_req_wait", bus8.req, 1'b1);
    check("w_addr_wait", bus8.addr, 6'h00);
    rst_n8 = 1'b0;
    #1;
    check("w_req_async_drop", bus8.req, 1'b0);
    check("w_rst_ip", u_core8.r_ip, 6'h00);
    step(1);
    rst_n8 = 1'b1;
    step(5);
    check("w_lat3_exec_noreq", bus8.req, 1'b0);
    check("w_lat3_a_before", u_core8.r_a, 8'h00);
    step(1);
    check("w_lat3_a", u_core8.r_a, 8'h05);
    check("w_lat3_ip", u_core8.r_ip, 6'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
